// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: payload + control under valid/ready, with busywait stall and flush.
// Build option PIPE_SKID_EN adds a skid register so in_ready has no combinational path from out_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busywait,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  // Handshake: a side transfers at a rising edge when valid && ready are both high
  // (output side additionally requires !busywait); valid never depends on ready.
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              in_fire;
  logic              out_fire;

  assign out_fire = main_valid && out_ready && !busywait;
  assign in_fire  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              main_load;

  assign in_ready  = reset && !skid_valid && !busywait;
  assign main_load = !main_valid || out_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      // Payload bits stay put; only the valid flags are killed.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!busywait) begin
      if (main_load) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
          main_ctrl  <= skid_ctrl;
          skid_valid <= in_fire;
          if (in_fire) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end
        end else begin
          main_valid <= in_fire;
          if (in_fire) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end
        end
      end else if (in_fire) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_ctrl  <= in_ctrl;
      end
    end
  end
`else
  assign in_ready = reset && (!main_valid || out_ready) && !busywait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (!busywait) begin
      if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_ctrl  <= in_ctrl;
      end else if (out_fire) begin
        main_valid <= 1'b0;
      end
    end
  end
`endif

  // An invalid entry presents a zero control field so a bubble decodes as a NOP.
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, flush, busywait, async reset.
// Expectations adapt to whether PIPE_SKID_EN is defined.
module tb_pipe_stage_reg;
  localparam int DATA_W = 160;
  localparam int CTRL_W = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic              busywait;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  int checks = 0;
  int errors = 0;
  logic [CTRL_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .busywait(busywait), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
  );

  function automatic logic [DATA_W-1:0] data_of(input logic [CTRL_W-1:0] c);
    return {5{8'hC3, c}};
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [CTRL_W-1:0] c);
    check({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(v));
    check({tag, "_ctrl"}, DATA_W'(out_ctrl), DATA_W'(c));
    if (v) check({tag, "_data"}, out_data, data_of(c));
  endtask

  task automatic expect_ready(input string tag, input logic r);
    check(tag, DATA_W'(in_ready), DATA_W'(r));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = data_of(c);
  endtask

  // scoreboard: every output transfer must match the next expected control value
  always @(negedge clk) begin
    if (reset && out_valid && out_ready && !busywait) begin
      if (exp_q.size() == 0) begin
        check("sb_extra", DATA_W'(out_valid), DATA_W'(1'b0));
      end else begin
        logic [CTRL_W-1:0] e;
        e = exp_q.pop_front();
        check("sb_order", DATA_W'(out_ctrl), DATA_W'(e));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b0; busywait = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    @(negedge clk);
    expect_out("rst", 1'b0, '0);
    check("rst_data", out_data, '0);
    expect_ready("rst_in_ready", 1'b0);
    tick();
    reset = 1'b1;

    // streaming: 8 back-to-back entries
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, CTRL_W'(k));
      @(negedge clk);
      expect_ready("stream_in_ready", 1'b1);
      if (k == 1) expect_out("stream_first", 1'b0, '0);
      else expect_out("stream", 1'b1, CTRL_W'(k - 1));
      exp_q.push_back(CTRL_W'(k));
      tick();
    end
    drive(1'b0, '0);
    @(negedge clk);
    expect_out("stream_last", 1'b1, CTRL_W'(8));
    tick();
    @(negedge clk);
    expect_out("stream_drain", 1'b0, '0);

    // backpressure: A, B, C with out_ready low
    tick();
    out_ready = 1'b0;
    exp_q.push_back(CTRL_W'('hA));
    exp_q.push_back(CTRL_W'('hB));
    exp_q.push_back(CTRL_W'('hC));
    drive(1'b1, CTRL_W'('hA));
`ifdef PIPE_SKID_EN
    @(negedge clk);
    expect_ready("bp_rdy_a", 1'b1);
    expect_out("bp_empty", 1'b0, '0);
    tick();
    drive(1'b1, CTRL_W'('hB));
    @(negedge clk);
    expect_ready("bp_rdy_b", 1'b1);
    expect_out("bp_hold_a1", 1'b1, CTRL_W'('hA));
    tick();
    drive(1'b1, CTRL_W'('hC));
    @(negedge clk);
    expect_ready("bp_full", 1'b0);
    expect_out("bp_hold_a2", 1'b1, CTRL_W'('hA));
    #1 out_ready = 1'b1;
    #1 expect_ready("bp_no_comb", 1'b0);
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    expect_ready("bp_still_full", 1'b0);
    expect_out("bp_out_a", 1'b1, CTRL_W'('hA));
    tick();
    @(negedge clk);
    expect_ready("bp_rdy_c", 1'b1);
    expect_out("bp_out_b", 1'b1, CTRL_W'('hB));
    tick();
`else
    @(negedge clk);
    expect_ready("bp_rdy_a", 1'b1);
    expect_out("bp_empty", 1'b0, '0);
    tick();
    drive(1'b1, CTRL_W'('hB));
    @(negedge clk);
    expect_ready("bp_full", 1'b0);
    expect_out("bp_hold_a1", 1'b1, CTRL_W'('hA));
    #1 out_ready = 1'b1;
    #1 expect_ready("bp_comb_hi", 1'b1);
    out_ready = 1'b0;
    #1 expect_ready("bp_comb_lo", 1'b0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    expect_ready("bp_rdy_b", 1'b1);
    expect_out("bp_out_a", 1'b1, CTRL_W'('hA));
    tick();
    drive(1'b1, CTRL_W'('hC));
    @(negedge clk);
    expect_ready("bp_rdy_c", 1'b1);
    expect_out("bp_out_b", 1'b1, CTRL_W'('hB));
    tick();
`endif
    drive(1'b0, '0);
    @(negedge clk);
    expect_out("bp_out_c", 1'b1, CTRL_W'('hC));
    tick();
    @(negedge clk);
    expect_out("bp_drain", 1'b0, '0);

    // flush with the stage full and out_ready low
    tick();
    out_ready = 1'b0;
    drive(1'b1, CTRL_W'('hE));
    tick();
`ifdef PIPE_SKID_EN
    drive(1'b1, CTRL_W'('hF));
    tick();
`endif
    drive(1'b1, CTRL_W'('hD));
    flush = 1'b1;
    @(negedge clk);
    expect_ready("fl_a_rdy", 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    @(negedge clk);
    expect_out("fl_a", 1'b0, '0);
    check("fl_a_keep_data", out_data, data_of(CTRL_W'('hE)));
    expect_ready("fl_a_rdy_after", 1'b1);
    tick();
    @(negedge clk);
    expect_out("fl_a_idle", 1'b0, '0);

    // flush with a concurrent input transfer that must be discarded
    tick();
    out_ready = 1'b0;
    drive(1'b1, CTRL_W'('h10));
    exp_q.push_back(CTRL_W'('h10));
    tick();
    drive(1'b1, CTRL_W'('hD));
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    expect_ready("fl_b_rdy", 1'b1);
    expect_out("fl_b_pre", 1'b1, CTRL_W'('h10));
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    @(negedge clk);
    expect_out("fl_b", 1'b0, '0);
    check("fl_b_keep_data", out_data, data_of(CTRL_W'('h10)));
    tick();
    @(negedge clk);
    expect_out("fl_b_no_d", 1'b0, '0);

    // busywait for 3 cycles with an entry stored
    tick();
    out_ready = 1'b0;
    drive(1'b1, CTRL_W'('h11));
    tick();
    drive(1'b1, CTRL_W'('h12));
    out_ready = 1'b1;
    busywait = 1'b1;
    exp_q.push_back(CTRL_W'('h11));
    exp_q.push_back(CTRL_W'('h12));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_ready("bw_rdy", 1'b0);
      expect_out("bw_hold", 1'b1, CTRL_W'('h11));
      tick();
    end
    busywait = 1'b0;
    @(negedge clk);
    expect_ready("bw_release_rdy", 1'b1);
    expect_out("bw_release", 1'b1, CTRL_W'('h11));
    tick();
    drive(1'b0, '0);
    @(negedge clk);
    expect_out("bw_next", 1'b1, CTRL_W'('h12));
    tick();
    @(negedge clk);
    expect_out("bw_drain", 1'b0, '0);

    // asynchronous reset between edges with entries stored
    tick();
    out_ready = 1'b0;
    drive(1'b1, CTRL_W'('h13));
    tick();
`ifdef PIPE_SKID_EN
    drive(1'b1, CTRL_W'('h14));
    tick();
`endif
    drive(1'b0, '0);
    #1 reset = 1'b0;
    #1;
    expect_out("rst_async", 1'b0, '0);
    check("rst_async_data", out_data, '0);
    expect_ready("rst_async_rdy", 1'b0);
    tick();
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, CTRL_W'('h15));
    exp_q.push_back(CTRL_W'('h15));
    @(negedge clk);
    expect_ready("rst_rel_rdy", 1'b1);
    expect_out("rst_rel", 1'b0, '0);
    tick();
    drive(1'b0, '0);
    @(negedge clk);
    expect_out("rst_first", 1'b1, CTRL_W'('h15));
    tick();
    @(negedge clk);
    expect_out("rst_drain", 1'b0, '0);

    check("sb_empty", DATA_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the per-stage hand-written pipe registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a data payload and a control field under a valid/ready handshake. It honours the global `busywait` stall and adds a `flush` input that turns stored entries into bubbles, which the fixed-function stage registers lack. It sits between any two pipeline stages of the RISC-V core and provides one cycle of latency at full throughput.

## Interface
- `DATA_W`, default 160: payload width (instruction, PC, operands, immediate). Never cleared by flush.
- `CTRL_W`, default 24: control-field width (selects, alu_op, branch_jump, read_write, wb_sel, reg_write_en). Forced to zero whenever the entry is invalid, so a bubble is a NOP.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `busywait` input 1: global memory stall; freezes all state while high.
- `flush` input 1: kill all stored entries (branch/jump redirect).
- `in_valid` input 1: upstream has an entry.
- `in_ready` output 1: stage can accept an entry.
- `in_data` input DATA_W: upstream payload.
- `in_ctrl` input CTRL_W: upstream control field.
- `out_valid` output 1: stage presents an entry.
- `out_ready` input 1: downstream accepts.
- `out_data` output DATA_W: presented payload.
- `out_ctrl` output CTRL_W: presented control field; `'0` when `out_valid`=0.

## Operation
- Transfers:
  - An input transfer is `in_valid && in_ready` at a rising edge.
  - An output transfer is `out_valid && out_ready && !busywait` at a rising edge.
- Priority: reset > flush > busywait > handshake.
- Reset (`reset`=0, asynchronous):
  - All valid flags clear.
  - `out_data`=0 and `out_ctrl`=0.
  - `in_ready`=0 while reset is asserted.
- Flush, sampled at an edge:
  - All stored valid flags clear, including during busywait.
  - An input transfer in the same cycle is discarded; upstream treats it as consumed.
  - Stored payload bits are left unchanged.
- Busywait:
  - `in_ready`=0, combinationally from `busywait`.
  - State is frozen and `out_ready` is ignored.
  - `out_valid`, `out_data` and `out_ctrl` hold their values.
- Storage, with `PIPE_SKID_EN` defined: a main register feeds the outputs, backed by a skid register; occupancy is 0–2.
  - `in_ready` = `!skid_valid && !busywait`; the state term is registered.
  - Input transfer while main is empty, or main drains in the same cycle → the entry goes to main.
  - Input transfer while main is full and not draining → the entry goes to skid.
  - Main drains while skid is valid → skid moves to main, and skid clears unless a new input transfer refills it.
  - Order is strictly FIFO; no entry is dropped or duplicated.
- Storage, without `PIPE_SKID_EN`: main register only; occupancy is 0–1.
  - `in_ready` = `(!main_valid || out_ready) && !busywait`, a combinational path from `out_ready`.
- `out_ctrl` = `main_valid ? main_ctrl : '0`. `out_data` = `main_data`, which is valid only when `out_valid`=1.

## Timing
- Latency: input transfer at edge N → `out_valid`=1 with that entry after edge N (cycle N+1).
- Throughput: one entry per cycle when `out_ready`=1 and `busywait`=0.
- With skid: after `out_ready` falls, one more entry is accepted; `in_ready` falls the cycle after skid fills.
- Without skid: `in_ready` follows `out_ready` in the same cycle.
- Release of `busywait`: the handshake resumes in that same cycle with no bubble inserted.
- Reset release: first accept possible at the first edge with `reset`=1 and `busywait`=0.

## Configuration
- `PIPE_SKID_EN` defined: 2-entry skid buffer; `in_ready` has no combinational dependence on `out_ready`, which cuts the backward timing path across stages.
- `PIPE_SKID_EN` undefined: single register with combinational `in_ready`; minimum area.
- Handshake protocol and flush/busywait semantics are identical in both builds.

## Test plan
- Streaming: DATA_W=160, CTRL_W=24, `out_ready`=1, 8 back-to-back entries with `in_ctrl`=1..8 → `out_ctrl`=1..8 on consecutive cycles, one cycle late, no gaps.
- Backpressure (skid build): `out_ready`=0 while sending A, B, C → A is held on the outputs, B is accepted into skid, `in_ready`=0 from the cycle after B. Raising `out_ready` → A, B, C emerge in order.
- Flush: two entries stored, `flush`=1 for one cycle with `in_valid`=1 carrying D → `out_valid`=0 and `out_ctrl`=0 next cycle; D never appears.
- Busywait: `busywait`=1 for 3 cycles with `out_ready`=1 and an entry stored → outputs held, `in_ready`=0, nothing consumed. After release the entry transfers on the first edge.
- Reset mid-operation: `reset` driven low asynchronously between edges with 2 entries stored → `out_valid`, `out_data` and `out_ctrl` go to 0 immediately. After release, the first new entry appears with 1-cycle latency.
- Both builds: rerun the streaming and backpressure cases without `PIPE_SKID_EN` → the same output sequence, and `in_ready` tracks `out_ready` combinationally.
